sv32_page_walker: RTL

Hardware page-table walker that reads the `satp` value held by the CSR register file and translates a 20-bit Sv32 virtual page number into a 22-bit physical page number. It sits between the MMU/TLB refill logic and the data memory port. It runs a two-level walk over a request/grant/rvalid memory interface and returns the leaf PTE flags, a superpage indication, or a page fault. In bare mode (`satp.MODE = 0`) it returns an identity translation without touching memory.

---
 rtl/sv32_page_walker.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/sv32_page_walker.sv
// Sv32 hardware page-table walker: two-level PTE walk over a req/gnt/rvalid read port,
// with identity translation when satp.MODE is bare.
module sv32_page_walker #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] satp_i,
    input  logic                  walk_req_i,
    input  logic [19:0]           walk_vpn_i,
    output logic                  walk_ready_o,
    output logic                  walk_valid_o,
    output logic [21:0]           walk_ppn_o,
    output logic [7:0]            walk_flags_o,
    output logic                  walk_superpage_o,
    output logic                  walk_fault_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StL1Req  = 3'd1;
    localparam logic [2:0] StL1Wait = 3'd2;
    localparam logic [2:0] StL0Req  = 3'd3;
    localparam logic [2:0] StL0Wait = 3'd4;
    localparam logic [2:0] StResp   = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [19:0] vpn_q, vpn_d;
    logic [21:0] root_q, root_d;
    logic [21:0] next_ppn_q, next_ppn_d;
    logic [21:0] ppn_q, ppn_d;
    logic [7:0]  flags_q, flags_d;
    logic        sp_q, sp_d;
    logic        fault_q, fault_d;

    logic [31:0] pte;
    logic [21:0] pte_ppn;
    logic        pte_bad;
    logic        pte_leaf;
    logic [33:0] addr_full;
    logic        unused_bits;

    assign pte      = mem_rdata_i[31:0];
    assign pte_ppn  = pte[31:10];
    assign pte_bad  = !pte[0] || (!pte[1] && pte[2]);
    assign pte_leaf = pte[1] || pte[3];

    // Only MODE and the root PPN of satp matter; RSW bits are not interpreted.
    assign unused_bits = ^{satp_i[30:22], mem_rdata_i[9:8]};

    always_comb begin
        state_d    = state_q;
        vpn_d      = vpn_q;
        root_d     = root_q;
        next_ppn_d = next_ppn_q;
        ppn_d      = ppn_q;
        flags_d    = flags_q;
        sp_d       = sp_q;
        fault_d    = fault_q;
        unique case (state_q)
            StIdle: begin
                if (walk_req_i) begin
                    vpn_d  = walk_vpn_i;
                    root_d = satp_i[21:0];
                    if (!satp_i[31]) begin
                        ppn_d   = {2'b00, walk_vpn_i};
                        flags_d = 8'h00;
                        sp_d    = 1'b0;
                        fault_d = 1'b0;
                        state_d = StResp;
                    end else begin
                        state_d = StL1Req;
                    end
                end
            end
            StL1Req: begin
                if (mem_gnt_i) state_d = StL1Wait;
            end
            StL1Wait: begin
                if (mem_rvalid_i) begin
                    if (!pte_bad && !pte_leaf) begin
                        next_ppn_d = pte_ppn;
                        state_d    = StL0Req;
                    end else begin
                        // Response registers change only when a walk completes.
                        flags_d = pte[7:0];
                        state_d = StResp;
                        if (pte_bad || (pte_ppn[9:0] != 10'd0)) begin
                            ppn_d   = 22'd0;
                            sp_d    = 1'b0;
                            fault_d = 1'b1;
                        end else begin
                            ppn_d   = {pte_ppn[21:10], vpn_q[9:0]};
                            sp_d    = 1'b1;
                            fault_d = 1'b0;
                        end
                    end
                end
            end
            StL0Req: begin
                if (mem_gnt_i) state_d = StL0Wait;
            end
            StL0Wait: begin
                if (mem_rvalid_i) begin
                    flags_d = pte[7:0];
                    sp_d    = 1'b0;
                    state_d = StResp;
                    if (pte_bad || !pte_leaf) begin
                        ppn_d   = 22'd0;
                        fault_d = 1'b1;
                    end else begin
                        ppn_d   = pte_ppn;
                        fault_d = 1'b0;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= StIdle;
            vpn_q      <= 20'd0;
            root_q     <= 22'd0;
            next_ppn_q <= 22'd0;
            ppn_q      <= 22'd0;
            flags_q    <= 8'h00;
            sp_q       <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            vpn_q      <= vpn_d;
            root_q     <= root_d;
            next_ppn_q <= next_ppn_d;
            ppn_q      <= ppn_d;
            flags_q    <= flags_d;
            sp_q       <= sp_d;
            fault_q    <= fault_d;
        end
    end

    // The 34-bit physical PTE address is cut down to the port width.
    assign addr_full = (state_q == StL0Req) ? {next_ppn_q, vpn_q[9:0], 2'b00}
                                            : {root_q, vpn_q[19:10], 2'b00};

    assign mem_addr_o       = ADDR_WIDTH'(addr_full);
    assign mem_req_o        = (state_q == StL1Req) || (state_q == StL0Req);
    assign walk_ready_o     = (state_q == StIdle);
    assign walk_valid_o     = (state_q == StResp);
    assign walk_ppn_o       = ppn_q;
    assign walk_flags_o     = flags_q;
    assign walk_superpage_o = sp_q;
    assign walk_fault_o     = fault_q;

endmodule
